add_sub_accum_ctrl: RTL

Sequential accumulate controller that sits directly upstream of the combinational signed add/sub unit and consumes its result. It accepts a burst of signed operands over a valid/ready stream and drives the running accumulator and each operand into the adder. It registers the adder output back as the new accumulator and, after the last operand, presents the final sum with a sticky overflow flag on a valid/ready result port.

---
 rtl/add_sub_accum_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/add_sub_accum_ctrl.sv
// add_sub_accum_ctrl: burst accumulate controller wrapped around an external
// combinational signed add/sub unit.
//
// Accepts len_i signed operands over a valid/ready stream. Each operand is
// steered into the adder together with the running accumulator. The adder
// result is registered back as the new accumulator. After the last operand,
// the final sum and a sticky signed-overflow flag are offered on a
// valid/ready result port.
//
// Optional feature: define ACC_SAT_EN to saturate the accumulator on a beat
// that overflows. When it is undefined, the accumulator wraps modulo 2^W.
//
// Ports:
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   start_i, len_i          begin a burst of len_i operands (sampled in IDLE)
//   op_valid_i/op_ready_o   operand stream handshake
//   op_data_i, op_sub_i     signed operand, 1 = subtract
//   add_a_o/add_b_o/
//   add_sub_nadd_o          drive the external adder
//   add_out_i, add_carry_i  adder result (carry unused)
//   res_valid_o/res_ready_i result handshake
//   res_data_o, res_ovf_o   final accumulator, sticky overflow
//   busy_o                  burst in progress (RUN or HOLD)
module add_sub_accum_ctrl #(
  parameter int unsigned DATA_IN_W = 16,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic [CNT_W-1:0]     len_i,
  input  logic                 op_valid_i,
  output logic                 op_ready_o,
  input  logic [DATA_IN_W-1:0] op_data_i,
  input  logic                 op_sub_i,
  output logic [DATA_IN_W-1:0] add_a_o,
  output logic [DATA_IN_W-1:0] add_b_o,
  output logic                 add_sub_nadd_o,
  input  logic [DATA_IN_W-1:0] add_out_i,
  input  logic                 add_carry_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [DATA_IN_W-1:0] res_data_o,
  output logic                 res_ovf_o,
  output logic                 busy_o
);

  localparam int unsigned MSB = DATA_IN_W - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_IN_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  logic beat;
  logic beat_ovf;
  logic sign_a, sign_b, sign_r;

  // Carry out is meaningless for two's-complement overflow detection.
  logic carry_unused;
  assign carry_unused = add_carry_i;

  // Adder drive: accumulator and operand go straight to the external unit.
  assign add_a_o        = acc_q;
  assign add_b_o        = op_data_i;
  assign add_sub_nadd_o = op_sub_i;

  // Outputs decoded from registered state only.
  assign op_ready_o  = (state_q == RUN);
  assign res_valid_o = (state_q == HOLD);
  assign busy_o      = (state_q != IDLE);
  assign res_data_o  = acc_q;
  assign res_ovf_o   = ovf_q;

  // Per-beat signed overflow from operand and result sign bits.
  assign sign_a   = acc_q[MSB];
  assign sign_b   = op_data_i[MSB];
  assign sign_r   = add_out_i[MSB];
  assign beat     = (state_q == RUN) && op_valid_i;
  assign beat_ovf = (op_sub_i ? (sign_a != sign_b) : (sign_a == sign_b))
                    && (sign_r != sign_a);

`ifdef ACC_SAT_EN
  // Clamp toward the sign of the pre-beat accumulator.
  logic [DATA_IN_W-1:0] sat_val;
  assign sat_val = sign_a ? {1'b1, {(DATA_IN_W-1){1'b0}}}
                          : {1'b0, {(DATA_IN_W-1){1'b1}}};
`endif

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          acc_d = '0;
          ovf_d = 1'b0;
          cnt_d = len_i;
          state_d = (len_i == '0) ? HOLD : RUN;
        end
      end
      RUN: begin
        if (beat) begin
`ifdef ACC_SAT_EN
          acc_d = beat_ovf ? sat_val : add_out_i;
`else
          acc_d = add_out_i;
`endif
          ovf_d = ovf_q | beat_ovf;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (res_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
